div_sched: RTL and testbench

Run/stop and ratio controller for the team's counter-based clock divider. It owns a free-running divide counter and sequences it. Divide-ratio updates are accepted through a valid/ready handshake and applied only at a period boundary, so downstream logic never sees a truncated or stretched period. It sits between the configuration register interface and the consumers of the divided enable (`tick`) and divided square wave (`div_out`).

---
 rtl/div_sched.sv | 115 +++++++++++
 tb/tb_div_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Run/stop and ratio controller for the counter-based clock divider.
// Ratio updates arrive by valid/ready and take effect only on a period boundary.
module div_sched #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             tick,
    output logic             div_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    // Handshake: a ratio transfers on any rising edge where cfg_valid && cfg_ready;
    // cfg_ready drops only while a ratio is pending, so at most one can be held.
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_cfg_err;

    logic             w_xfer;
    logic             w_ok;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_high_from;
    logic             w_wrap;

    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_ok        = (cfg_div >= CNT_W'(2));
    assign w_last      = r_cur_div - CNT_W'(1);
    assign w_high_from = r_cur_div - (r_cur_div >> 1);
    assign w_wrap      = (r_state != ST_IDLE) && (r_cnt == w_last);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!run)                w_next = ST_IDLE;
                else if (w_xfer && w_ok) w_next = ST_PEND;
            end
            ST_PEND: begin
                if (!run)        w_next = ST_IDLE;
                else if (w_wrap) w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state != ST_PEND);
        busy      = (r_state == ST_PEND);
        tick      = (r_state != ST_IDLE) && (r_cnt == w_last);
        div_out   = (r_state != ST_IDLE) && (r_cnt >= w_high_from);
        dbg_state = r_state;
        cur_div   = r_cur_div;
        cfg_err   = r_cfg_err;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cnt      <= '0;
            r_cur_div  <= DEF_DIV_C;
            r_pend_div <= DEF_DIV_C;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && !w_ok;

            // Entering, leaving or sitting in IDLE restarts the period at 0.
            if ((w_next == ST_IDLE) || (r_state == ST_IDLE) || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Outside a running period a ratio can be applied immediately.
            if (w_xfer && w_ok && ((r_state == ST_IDLE) || ((r_state == ST_RUN) && !run))) begin
                r_cur_div <= cfg_div;
            end else if ((r_state == ST_PEND) && (!run || w_wrap)) begin
                r_cur_div <= r_pend_div;
            end

            if ((r_state == ST_RUN) && run && w_xfer && w_ok) begin
                r_pend_div <= cfg_div;
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Scenario bench for div_sched: per-cycle {tick, div_out} expectations are queued
// from fixed period tables and compared as the divider produces them.
module tb_div_sched;

    localparam int CNT_W = 8;

    logic             clk;
    logic             nRst;
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [CNT_W-1:0] cur_div;
    logic             tick;
    logic             div_out;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_vec;
    int n_err;

    logic [1:0] exp_q[$];

    div_sched #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div),
        .tick      (tick),
        .div_out   (div_out),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One period of {tick, div_out} per ratio, low phase first.
    task automatic push_period(input int n);
        case (n)
            3: begin
                exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b11);
            end
            4: begin
                exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b01);
                exp_q.push_back(2'b11);
            end
            5: begin
                exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b00);
                exp_q.push_back(2'b01); exp_q.push_back(2'b11);
            end
            6: begin
                exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b00);
                exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b11);
            end
            default: begin
                for (int c = 0; c < n; c++) exp_q.push_back(2'b00);
            end
        endcase
    endtask

    task automatic test_reset();
        logic [1:0] got;
        nRst = 1'b0; run = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
        step(); step();
        n_vec++; got = {tick, div_out};
        if (got !== 2'b00) begin n_err++; $display("FAIL reset_outs: got %b expected 00", got); end
        n_vec++;
        if (cur_div !== 8'd4) begin n_err++; $display("FAIL reset_cur_div: got %0d expected 4", cur_div); end
        n_vec++; got = {cfg_ready, busy};
        if (got !== 2'b10) begin n_err++; $display("FAIL reset_ready_busy: got %b expected 10", got); end
        n_vec++;
        if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    endtask

    task automatic test_run_default();
        logic [1:0] got, exp;
        nRst = 1'b1;
        push_period(4); push_period(4); push_period(4);
        for (int i = 0; i < 12; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL run_default_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL run_default[%0d]: got %b expected %b", i, got, exp); end
            end
        end
        n_vec++;
        if (cur_div !== 8'd4) begin n_err++; $display("FAIL run_default_cur_div: got %0d expected 4", cur_div); end
    endtask

    task automatic test_ratio_update();
        logic [1:0] got, exp;
        push_period(4); push_period(5); push_period(5);
        for (int i = 0; i < 14; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL ratio_update_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL ratio_update[%0d]: got %b expected %b", i, got, exp); end
            end
            if (i == 2 || i == 3) begin
                n_vec++;
                if ({busy, cfg_ready} !== 2'b10) begin
                    n_err++; $display("FAIL ratio_pending[%0d]: got busy/ready %b%b expected 10", i, busy, cfg_ready);
                end
            end
            if (i == 4) begin
                n_vec++;
                if ({busy, cfg_ready} !== 2'b01) begin
                    n_err++; $display("FAIL ratio_applied_flags: got busy/ready %b%b expected 01", busy, cfg_ready);
                end
                n_vec++;
                if (cur_div !== 8'd5) begin n_err++; $display("FAIL ratio_applied_div: got %0d expected 5", cur_div); end
            end
            if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd5; end
            if (i == 2) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_invalid_ratio();
        logic [1:0] got, exp;
        int pulses;
        pulses = 0;
        cfg_valid = 1'b1; cfg_div = 8'd1;
        push_period(5); push_period(5);
        for (int i = 0; i < 10; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL invalid_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL invalid[%0d]: got %b expected %b", i, got, exp); end
            end
            if (cfg_err === 1'b1) pulses++;
            if (i == 0) begin
                cfg_valid = 1'b0;
                n_vec++;
                if (cfg_err !== 1'b1) begin n_err++; $display("FAIL invalid_err_pulse: got %b expected 1", cfg_err); end
                n_vec++;
                if ({cfg_ready, busy} !== 2'b10) begin n_err++; $display("FAIL invalid_ready: got ready/busy %b%b expected 10", cfg_ready, busy); end
            end
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL invalid_pulse_count: got %0d expected 1", pulses); end
        n_vec++;
        if (cur_div !== 8'd5) begin n_err++; $display("FAIL invalid_cur_div: got %0d expected 5", cur_div); end
    endtask

    task automatic test_stop_pending();
        logic [1:0] got, exp;
        for (int c = 0; c < 5; c++) exp_q.push_back(2'b00);
        push_period(6); push_period(6);
        for (int i = 0; i < 17; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL stop_pend_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL stop_pend[%0d]: got %b expected %b", i, got, exp); end
            end
            if (i == 1) begin
                n_vec++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL stop_pend_busy: got %b expected 1", busy); end
            end
            if (i == 3) begin
                n_vec++;
                if (cur_div !== 8'd6) begin n_err++; $display("FAIL stop_pend_cur_div: got %0d expected 6", cur_div); end
                n_vec++;
                if ({busy, dbg_state} !== 3'b000) begin n_err++; $display("FAIL stop_pend_idle: got busy/state %b/%b expected 0/00", busy, dbg_state); end
            end
            if (i == 0) begin cfg_valid = 1'b1; cfg_div = 8'd6; end
            if (i == 1) cfg_valid = 1'b0;
            if (i == 2) run = 1'b0;
            if (i == 4) run = 1'b1;
        end
    endtask

    task automatic test_idle_accept();
        logic [1:0] got, exp;
        run = 1'b0;
        exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        push_period(3); push_period(3);
        for (int i = 0; i < 8; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL idle_accept_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL idle_accept[%0d]: got %b expected %b", i, got, exp); end
            end
            if (i == 2) begin
                cfg_valid = 1'b0;
                n_vec++;
                if (cur_div !== 8'd3) begin n_err++; $display("FAIL idle_accept_cur_div: got %0d expected 3", cur_div); end
                n_vec++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL idle_accept_busy: got %b expected 0", busy); end
            end
            if (i == 1) begin run = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd3; end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] got, exp;
        cfg_valid = 1'b1; cfg_div = 8'd8;
        push_period(3);
        for (int c = 0; c < 3; c++) exp_q.push_back(2'b00);
        for (int i = 0; i < 6; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL b2b[%0d]: got %b expected %b", i, got, exp); end
            end
            if (i == 0) begin
                cfg_valid = 1'b0;
                n_vec++;
                if ({busy, cur_div} !== {1'b1, 8'd3}) begin n_err++; $display("FAIL b2b_pend: got busy/div %b/%0d expected 1/3", busy, cur_div); end
            end
            if (i == 3) begin
                n_vec++;
                if ({busy, cur_div} !== {1'b0, 8'd8}) begin n_err++; $display("FAIL b2b_applied: got busy/div %b/%0d expected 0/8", busy, cur_div); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] got, exp;
        #2 nRst = 1'b0;
        #1;
        got = {tick, div_out}; n_vec++;
        if (got !== 2'b00) begin n_err++; $display("FAIL async_rst_outs: got %b expected 00", got); end
        n_vec++;
        if (cur_div !== 8'd4) begin n_err++; $display("FAIL async_rst_cur_div: got %0d expected 4", cur_div); end
        n_vec++;
        if ({cfg_ready, busy} !== 2'b10) begin n_err++; $display("FAIL async_rst_flags: got ready/busy %b%b expected 10", cfg_ready, busy); end
        step();
        nRst = 1'b1;
        push_period(4);
        for (int i = 0; i < 4; i++) begin
            step();
            got = {tick, div_out}; n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL restart_q[%0d]: got %b expected queued entry", i, got); end
            else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL restart[%0d]: got %b expected %b", i, got, exp); end
            end
        end
    endtask

    task automatic test_reject_zero_idle();
        run = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_err !== 1'b1) begin n_err++; $display("FAIL zero_err: got %b expected 1", cfg_err); end
        n_vec++;
        if (cur_div !== 8'd4) begin n_err++; $display("FAIL zero_cur_div: got %0d expected 4", cur_div); end
        n_vec++;
        if (dbg_state !== 2'd0) begin n_err++; $display("FAIL zero_state: got %0d expected 0", dbg_state); end
        step();
        n_vec++;
        if (cfg_err !== 1'b0) begin n_err++; $display("FAIL zero_err_clear: got %b expected 0", cfg_err); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_run_default();
        test_ratio_update();
        test_invalid_ratio();
        test_stop_pending();
        test_idle_accept();
        test_back_to_back();
        test_async_reset();
        test_reject_zero_idle();
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_queue: got %0d entries expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
